// File: rtl/mips_pipeline_control.sv
// Control unit for a 5-stage MIPS pipeline (IF/ID/EX/MA/WB).
// Decodes the ID instruction and carries the control bundle through the
// ID/EX, EX/MA and MA/WB registers. It resolves load-use hazards,
// multi-cycle MUL occupancy, BEQ/BNE in EX and J in ID, and it keeps a
// saturating count of stalled cycles.
module mips_pipeline_control #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  alu_zero_ex,
  output logic                  PC_load,
  output logic                  EN_to_pipelineReg1,
  output logic                  flush_ifid,
  output logic                  select_jumpD,
  output logic                  branch_taken,
  output logic                  ex_RegDst,
  output logic                  ex_ALUsrc,
  output logic                  ex_Slt_select,
  output logic                  ex_shift_or_not,
  output logic                  ex_shift_direction,
  output logic [2:0]            ex_ALUOp,
  output logic                  ma_MemRead,
  output logic                  ma_MemWrite,
  output logic                  wb_RegWrite,
  output logic                  wb_MemtoReg,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NOP = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b101100;

  // Counter only needs to reach MUL_CYCLES-1; keep at least one bit.
  localparam int             MC_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MC_W-1:0] MUL_LAST = MC_W'(MUL_CYCLES - 1);

  typedef struct packed {
    logic                  regdst;
    logic                  alusrc;
    logic                  slt;
    logic                  shift;
    logic                  dir;
    logic [2:0]            aluop;
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  branch;
    logic                  is_bne;
    logic [REG_ADDR_W-1:0] dest;
  } ex_bundle_t;

  typedef struct packed {
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] dest;
  } ma_bundle_t;

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] dest;
  } wb_bundle_t;

  // A bubble is all-zero except for the NOP ALU code.
  localparam ex_bundle_t EX_BUBBLE =
    ex_bundle_t'({5'b00000, ALU_NOP, 6'b000000, {REG_ADDR_W{1'b0}}});

  ex_bundle_t            w_dec;
  logic                  w_raw_we;
  logic                  w_jump;
  logic                  w_uses_rt;
  logic [REG_ADDR_W-1:0] w_dest_sel;

  ex_bundle_t            r_idex;
  ma_bundle_t            r_exma;
  wb_bundle_t            r_mawb;
  logic [MC_W-1:0]       r_mul_cnt;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic                  w_branch_taken;
  logic                  w_ex_is_mul;
  logic                  w_mul_stall;
  logic                  w_load_use;
  logic                  w_stall;
  logic                  w_jump_go;

  // ID decode: opcode/funct to the EX control bundle plus ID-only jump/uses_rt.
  always_comb begin
    w_dec      = EX_BUBBLE;
    w_raw_we   = 1'b0;
    w_jump     = 1'b0;
    w_uses_rt  = 1'b0;
    if (instr_valid) begin
      case (opcode)
        OP_RTYPE: begin
          w_uses_rt    = 1'b1;
          w_dec.regdst = 1'b1;
          w_raw_we     = 1'b1;
          case (funct)
            F_ADD:   w_dec.aluop = ALU_ADD;
            F_SUB:   w_dec.aluop = ALU_SUB;
            F_AND:   w_dec.aluop = ALU_AND;
            F_OR:    w_dec.aluop = ALU_OR;
            F_XOR:   w_dec.aluop = ALU_XOR;
            F_MUL:   w_dec.aluop = ALU_MUL;
            F_SLT:   w_dec.slt   = 1'b1;
            F_SLL:   w_dec.shift = 1'b1;
            F_SRL: begin
              w_dec.shift = 1'b1;
              w_dec.dir   = 1'b1;
            end
            default: w_raw_we = 1'b0;
          endcase
        end
        OP_ADDI: begin
          w_dec.alusrc = 1'b1;
          w_dec.aluop  = ALU_ADD;
          w_raw_we     = 1'b1;
        end
        OP_ANDI: begin
          w_dec.alusrc = 1'b1;
          w_dec.aluop  = ALU_AND;
          w_raw_we     = 1'b1;
        end
        OP_ORI: begin
          w_dec.alusrc = 1'b1;
          w_dec.aluop  = ALU_OR;
          w_raw_we     = 1'b1;
        end
        OP_SLTI: begin
          w_dec.alusrc = 1'b1;
          w_dec.aluop  = ALU_OR;
          w_dec.slt    = 1'b1;
          w_raw_we     = 1'b1;
        end
        OP_LW: begin
          w_dec.alusrc   = 1'b1;
          w_dec.aluop    = ALU_ADD;
          w_dec.memread  = 1'b1;
          w_dec.memtoreg = 1'b1;
          w_raw_we       = 1'b1;
        end
        OP_SW: begin
          w_dec.alusrc   = 1'b1;
          w_dec.aluop    = ALU_ADD;
          w_dec.memwrite = 1'b1;
          w_uses_rt      = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          w_dec.aluop  = ALU_SUB;
          w_dec.branch = 1'b1;
          w_dec.is_bne = (opcode == OP_BNE);
          w_uses_rt    = 1'b1;
        end
        OP_J:    w_jump = 1'b1;
        default: ;
      endcase
    end
    // Writes to $0 are dropped; a non-writing instruction carries dest 0.
    w_dest_sel     = w_dec.regdst ? rd_id : rt_id;
    w_dec.regwrite = w_raw_we & (w_dest_sel != '0);
    w_dec.dest     = w_dec.regwrite ? w_dest_sel : '0;
  end

  // Hazard resolution, priority: branch > mul stall > load-use > jump.
  always_comb begin
    w_branch_taken = r_idex.branch & (r_idex.is_bne ? ~alu_zero_ex : alu_zero_ex);
    w_ex_is_mul    = (r_idex.aluop == ALU_MUL);
    w_mul_stall    = ~w_branch_taken & w_ex_is_mul & (r_mul_cnt < MUL_LAST);
    w_load_use     = ~w_branch_taken & ~w_mul_stall & r_idex.memread &
                     (r_idex.dest != '0) &
                     ((r_idex.dest == rs_id) | (w_uses_rt & (r_idex.dest == rt_id)));
    w_stall        = w_mul_stall | w_load_use;
    // Reset is folded in so the jump select cannot leak out while rst is high.
    w_jump_go      = w_jump & ~w_branch_taken & ~w_stall & ~rst;
  end

  // ID/EX: holds during MUL occupancy, bubbles on taken branch or load-use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex <= EX_BUBBLE;
    end else if (w_mul_stall) begin
      r_idex <= r_idex;
    end else if (w_branch_taken | w_load_use) begin
      r_idex <= EX_BUBBLE;
    end else begin
      r_idex <= w_dec;
    end
  end

  // EX/MA: takes a bubble behind a still-busy MUL, otherwise advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exma <= '0;
    end else if (w_mul_stall) begin
      r_exma <= '0;
    end else begin
      r_exma <= '{memread:  r_idex.memread,
                  memwrite: r_idex.memwrite,
                  regwrite: r_idex.regwrite,
                  memtoreg: r_idex.memtoreg,
                  dest:     r_idex.dest};
    end
  end

  // MA/WB: pure one-cycle delay of the MA bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mawb <= '0;
    end else begin
      r_mawb <= '{regwrite: r_exma.regwrite,
                  memtoreg: r_exma.memtoreg,
                  dest:     r_exma.dest};
    end
  end

  // MUL occupancy counter: counts the extra EX cycles, clears on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_cnt <= '0;
    end else if (w_mul_stall) begin
      r_mul_cnt <= r_mul_cnt + MC_W'(1);
    end else begin
      r_mul_cnt <= '0;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign PC_load            = ~w_stall;
  assign EN_to_pipelineReg1 = ~w_stall;
  assign flush_ifid         = w_branch_taken | w_jump_go;
  assign select_jumpD       = w_jump_go;
  assign branch_taken       = w_branch_taken;

  assign ex_RegDst          = r_idex.regdst;
  assign ex_ALUsrc          = r_idex.alusrc;
  assign ex_Slt_select      = r_idex.slt;
  assign ex_shift_or_not    = r_idex.shift;
  assign ex_shift_direction = r_idex.dir;
  assign ex_ALUOp           = r_idex.aluop;

  assign ma_MemRead         = r_exma.memread;
  assign ma_MemWrite        = r_exma.memwrite;

  assign wb_RegWrite        = r_mawb.regwrite;
  assign wb_MemtoReg        = r_mawb.memtoreg;
  assign wb_dest            = r_mawb.regwrite ? r_mawb.dest : '0;

  assign stall_count        = r_stall_cnt;

endmodule

// File: tb/tb_mips_pipeline_control.sv
// Testbench for mips_pipeline_control: scenario tasks drive the ID stage
// cycle by cycle and check hazard controls inline; a WB scoreboard pops the
// expected destination register whenever the DUT retires a register write.
module tb_mips_pipeline_control;
  localparam int AW = 5;
  localparam int MC = 3;
  localparam int CW = 16;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_XOR = 6'b100110, F_SLT = 6'b101010,
                         F_MUL = 6'b101100, F_SLL = 6'b000000, F_SRL = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [AW-1:0] rs_id = '0, rt_id = '0, rd_id = '0;
  logic alu_zero_ex = 1'b0;
  logic PC_load, EN_to_pipelineReg1, flush_ifid, select_jumpD, branch_taken;
  logic ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction;
  logic [2:0] ex_ALUOp;
  logic ma_MemRead, ma_MemWrite, wb_RegWrite, wb_MemtoReg;
  logic [AW-1:0] wb_dest;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail = 0;
  int exp_stalls = 0;
  logic [AW-1:0] q[$];

  mips_pipeline_control #(.REG_ADDR_W(AW), .MUL_CYCLES(MC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .alu_zero_ex(alu_zero_ex),
    .PC_load(PC_load), .EN_to_pipelineReg1(EN_to_pipelineReg1), .flush_ifid(flush_ifid),
    .select_jumpD(select_jumpD), .branch_taken(branch_taken),
    .ex_RegDst(ex_RegDst), .ex_ALUsrc(ex_ALUsrc), .ex_Slt_select(ex_Slt_select),
    .ex_shift_or_not(ex_shift_or_not), .ex_shift_direction(ex_shift_direction),
    .ex_ALUOp(ex_ALUOp), .ma_MemRead(ma_MemRead), .ma_MemWrite(ma_MemWrite),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dest(wb_dest),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  // WB scoreboard: every retired register write must match the next expected dest.
  always @(posedge clk) begin
    logic [AW-1:0] exp_d;
    #2;
    if (!rst) begin
      n_checks++;
      if (wb_RegWrite) begin
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: wb_dest=%0d written, expected no write", wb_dest);
        end else begin
          exp_d = q.pop_front();
          if (wb_dest !== exp_d) begin
            n_fail++;
            $display("FAIL wb_dest: got %0d expected %0d", wb_dest, exp_d);
          end
        end
      end else if (wb_dest !== '0) begin
        n_fail++;
        $display("FAIL wb_dest_idle: got %0d expected 0", wb_dest);
      end
    end
  end

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic z);
    @(negedge clk);
    instr_valid = v; opcode = op; funct = fn;
    rs_id = rs; rt_id = rt; rd_id = rd; alu_zero_ex = z;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'd0, 6'd0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, OP_J, 6'd0, 5'd2, '0, '0, 1'b1);
    n_checks++;
    if ({PC_load, EN_to_pipelineReg1, flush_ifid, select_jumpD, branch_taken} !== 5'b11000) begin
      n_fail++; $display("FAIL rst_ctrl: got %b expected 11000",
        {PC_load, EN_to_pipelineReg1, flush_ifid, select_jumpD, branch_taken});
    end
    n_checks++;
    if ({ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction, ex_ALUOp} !== 8'b00000111) begin
      n_fail++; $display("FAIL rst_ex: got %b expected 00000111",
        {ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction, ex_ALUOp});
    end
    n_checks++;
    if ({ma_MemRead, ma_MemWrite, wb_RegWrite, wb_MemtoReg, wb_dest} !== 9'b0) begin
      n_fail++; $display("FAIL rst_ma_wb: got %b expected 0",
        {ma_MemRead, ma_MemWrite, wb_RegWrite, wb_MemtoReg, wb_dest});
    end
    n_checks++;
    if (stall_count !== '0) begin
      n_fail++; $display("FAIL rst_stall_count: got %0d expected 0", stall_count);
    end
    idle(1);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_load_use;
    drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    q.push_back(5'd2);
    drive(1'b1, OP_R, F_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    n_checks++;
    if ({PC_load, EN_to_pipelineReg1, flush_ifid} !== 3'b000) begin
      n_fail++; $display("FAIL lu_stall: got %b expected 000", {PC_load, EN_to_pipelineReg1, flush_ifid});
    end
    exp_stalls++;
    drive(1'b1, OP_R, F_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    n_checks++;
    if ({PC_load, ex_ALUOp, ma_MemRead} !== 5'b1_111_1) begin
      n_fail++; $display("FAIL lu_release: got %b expected 11111", {PC_load, ex_ALUOp, ma_MemRead});
    end
    n_checks++;
    if (stall_count !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL lu_stall_count: got %0d expected %0d", stall_count, exp_stalls);
    end
    q.push_back(5'd3);
    idle(1);
    n_checks++;
    if ({ex_ALUOp, ex_RegDst, wb_MemtoReg} !== 5'b000_1_1) begin
      n_fail++; $display("FAIL lu_add_ex_late: got %b expected 00011", {ex_ALUOp, ex_RegDst, wb_MemtoReg});
    end
    idle(3);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL lu_drain: %0d writes outstanding expected 0", q.size());
    end
  endtask

  task automatic test_mul;
    drive(1'b1, OP_R, F_MUL, 5'd6, 5'd7, 5'd5, 1'b0);
    q.push_back(5'd5);
    for (int k = 0; k < MC - 1; k++) begin
      drive(1'b1, OP_R, F_ADD, 5'd9, 5'd10, 5'd8, 1'b0);
      n_checks++;
      if ({PC_load, EN_to_pipelineReg1, ex_ALUOp} !== 5'b00_010) begin
        n_fail++; $display("FAIL mul_stall_%0d: got %b expected 00010", k, {PC_load, EN_to_pipelineReg1, ex_ALUOp});
      end
      exp_stalls++;
    end
    drive(1'b1, OP_R, F_ADD, 5'd9, 5'd10, 5'd8, 1'b0);
    n_checks++;
    if (PC_load !== 1'b1 || stall_count !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL mul_release: PC_load=%b stall_count=%0d expected 1/%0d", PC_load, stall_count, exp_stalls);
    end
    q.push_back(5'd8);
    idle(1);
    n_checks++;
    if ({ex_ALUOp, wb_RegWrite} !== 4'b000_0) begin
      n_fail++; $display("FAIL mul_bubble_wb: got %b expected 0000", {ex_ALUOp, wb_RegWrite});
    end
    idle(1);
    n_checks++;
    if ({wb_RegWrite, wb_dest} !== {1'b1, 5'd5}) begin
      n_fail++; $display("FAIL mul_wb: got %b expected %b", {wb_RegWrite, wb_dest}, {1'b1, 5'd5});
    end
    idle(1);
    n_checks++;
    if ({wb_RegWrite, wb_dest} !== {1'b1, 5'd8}) begin
      n_fail++; $display("FAIL mul_add_wb_late: got %b expected %b", {wb_RegWrite, wb_dest}, {1'b1, 5'd8});
    end
    idle(2);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL mul_drain: %0d writes outstanding expected 0", q.size());
    end
  endtask

  task automatic test_branch;
    drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(1'b1, OP_R, F_ADD, 5'd1, 5'd1, 5'd11, 1'b1);
    n_checks++;
    if ({branch_taken, flush_ifid, select_jumpD, PC_load, ex_ALUOp} !== 7'b1101_001) begin
      n_fail++; $display("FAIL beq_taken: got %b expected 1101001",
        {branch_taken, flush_ifid, select_jumpD, PC_load, ex_ALUOp});
    end
    idle(1);
    n_checks++;
    if ({ex_ALUOp, branch_taken} !== 4'b111_0) begin
      n_fail++; $display("FAIL beq_idex_bubble: got %b expected 1110", {ex_ALUOp, branch_taken});
    end
    drive(1'b1, OP_BNE, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    drive(1'b1, OP_R, F_ADD, 5'd1, 5'd1, 5'd12, 1'b1);
    n_checks++;
    if ({branch_taken, flush_ifid} !== 2'b00) begin
      n_fail++; $display("FAIL bne_not_taken: got %b expected 00", {branch_taken, flush_ifid});
    end
    q.push_back(5'd12);
    drive(1'b1, OP_BNE, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    n_checks++;
    if ({ex_ALUOp, ex_RegDst} !== 4'b000_1) begin
      n_fail++; $display("FAIL bne_next_ex: got %b expected 0001", {ex_ALUOp, ex_RegDst});
    end
    drive(1'b1, OP_R, F_ADD, 5'd1, 5'd1, 5'd13, 1'b0);
    n_checks++;
    if ({branch_taken, flush_ifid} !== 2'b11) begin
      n_fail++; $display("FAIL bne_taken: got %b expected 11", {branch_taken, flush_ifid});
    end
    idle(4);
    n_checks++;
    if (q.size() != 0 || stall_count !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL br_drain: outstanding=%0d stall_count=%0d expected 0/%0d", q.size(), stall_count, exp_stalls);
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [7:0] ex;   // {RegDst, ALUsrc, Slt, shift, dir, ALUOp}
    logic       mw;
  } dec_t;

  task automatic test_decode;
    dec_t t[$];
    t.push_back('{OP_R, F_SUB, 8'b10000_001, 1'b0});
    t.push_back('{OP_R, F_AND, 8'b10000_100, 1'b0});
    t.push_back('{OP_R, F_OR,  8'b10000_101, 1'b0});
    t.push_back('{OP_R, F_XOR, 8'b10000_110, 1'b0});
    t.push_back('{OP_R, F_SLT, 8'b10100_111, 1'b0});
    t.push_back('{OP_R, F_SLL, 8'b10010_111, 1'b0});
    t.push_back('{OP_R, F_SRL, 8'b10011_111, 1'b0});
    t.push_back('{OP_R, 6'b111111, 8'b10000_111, 1'b0});
    t.push_back('{OP_ADDI, 6'd0, 8'b01000_000, 1'b0});
    t.push_back('{OP_ANDI, 6'd0, 8'b01000_100, 1'b0});
    t.push_back('{OP_ORI,  6'd0, 8'b01000_101, 1'b0});
    t.push_back('{OP_SLTI, 6'd0, 8'b01100_101, 1'b0});
    t.push_back('{OP_SW,   6'd0, 8'b01000_000, 1'b1});
    t.push_back('{OP_BEQ,  6'd0, 8'b00000_001, 1'b0});
    t.push_back('{OP_J,    6'd0, 8'b00000_111, 1'b0});
    foreach (t[i]) begin
      drive(1'b1, t[i].op, t[i].fn, '0, '0, '0, 1'b0);
      idle(1);
      n_checks++;
      if ({ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction, ex_ALUOp} !== t[i].ex) begin
        n_fail++; $display("FAIL dec_ex_%0d: got %b expected %b", i,
          {ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction, ex_ALUOp}, t[i].ex);
      end
      idle(1);
      n_checks++;
      if (ma_MemWrite !== t[i].mw) begin
        n_fail++; $display("FAIL dec_ma_%0d: MemWrite=%b expected %b", i, ma_MemWrite, t[i].mw);
      end
    end
    idle(2);
  endtask

  task automatic test_jump_stall;
    drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    q.push_back(5'd2);
    drive(1'b1, OP_J, 6'd0, 5'd2, 5'd0, 5'd0, 1'b0);
    n_checks++;
    if ({PC_load, select_jumpD, flush_ifid} !== 3'b000) begin
      n_fail++; $display("FAIL j_during_stall: got %b expected 000", {PC_load, select_jumpD, flush_ifid});
    end
    exp_stalls++;
    drive(1'b1, OP_J, 6'd0, 5'd2, 5'd0, 5'd0, 1'b0);
    n_checks++;
    if ({PC_load, select_jumpD, flush_ifid} !== 3'b111) begin
      n_fail++; $display("FAIL j_after_stall: got %b expected 111", {PC_load, select_jumpD, flush_ifid});
    end
    idle(4);
    n_checks++;
    if (q.size() != 0 || stall_count !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL j_drain: outstanding=%0d stall_count=%0d expected 0/%0d", q.size(), stall_count, exp_stalls);
    end
  endtask

  task automatic test_zero_dest_unknown;
    drive(1'b1, OP_ADDI, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 6'b111111, F_ADD, 5'd3, 5'd4, 5'd9, 1'b0);
    n_checks++;
    if ({ex_ALUsrc, ex_RegDst, ex_ALUOp} !== 5'b10_000) begin
      n_fail++; $display("FAIL addi_ex: got %b expected 10000", {ex_ALUsrc, ex_RegDst, ex_ALUOp});
    end
    idle(1);
    n_checks++;
    if ({ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction, ex_ALUOp} !== 8'b00000_111) begin
      n_fail++; $display("FAIL unk_ex_bubble: got %b expected 00000111",
        {ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction, ex_ALUOp});
    end
    idle(1);
    n_checks++;
    if ({wb_RegWrite, wb_dest} !== 6'b0) begin
      n_fail++; $display("FAIL addi_r0_wb: got %b expected 0", {wb_RegWrite, wb_dest});
    end
    idle(1);
    n_checks++;
    if ({wb_RegWrite, wb_MemtoReg, wb_dest, ma_MemRead, ma_MemWrite} !== 9'b0) begin
      n_fail++; $display("FAIL unk_wb_bubble: got %b expected 0",
        {wb_RegWrite, wb_MemtoReg, wb_dest, ma_MemRead, ma_MemWrite});
    end
    idle(1);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL zd_drain: %0d writes outstanding expected 0", q.size());
    end
  endtask

  task automatic test_reset_mid_mul;
    drive(1'b1, OP_R, F_MUL, 5'd6, 5'd7, 5'd5, 1'b0);
    drive(1'b1, OP_R, F_ADD, 5'd1, 5'd1, 5'd14, 1'b0);
    drive(1'b1, OP_R, F_ADD, 5'd1, 5'd1, 5'd14, 1'b0);
    n_checks++;
    if (PC_load !== 1'b0) begin
      n_fail++; $display("FAIL rm_stall2: PC_load=%b expected 0", PC_load);
    end
    #1 rst = 1'b1;
    q.delete();
    exp_stalls = 0;
    #1;
    n_checks++;
    if ({PC_load, EN_to_pipelineReg1, flush_ifid, select_jumpD, branch_taken, ex_ALUOp} !== 8'b11000_111) begin
      n_fail++; $display("FAIL rm_ctrl: got %b expected 11000111",
        {PC_load, EN_to_pipelineReg1, flush_ifid, select_jumpD, branch_taken, ex_ALUOp});
    end
    n_checks++;
    if (stall_count !== '0) begin
      n_fail++; $display("FAIL rm_stall_count: got %0d expected 0", stall_count);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    drive(1'b1, OP_R, F_ADD, 5'd1, 5'd1, 5'd14, 1'b0);
    n_checks++;
    if (PC_load !== 1'b1) begin
      n_fail++; $display("FAIL rm_no_residual: PC_load=%b expected 1", PC_load);
    end
    q.push_back(5'd14);
    drive(1'b1, OP_R, F_MUL, 5'd6, 5'd7, 5'd5, 1'b0);
    n_checks++;
    if ({PC_load, ex_ALUOp} !== 4'b1_000) begin
      n_fail++; $display("FAIL rm_add_ex: got %b expected 1000", {PC_load, ex_ALUOp});
    end
    q.push_back(5'd5);
    for (int k = 0; k < MC - 1; k++) begin
      idle(1);
      n_checks++;
      if (PC_load !== 1'b0) begin
        n_fail++; $display("FAIL rm_mul_stall_%0d: PC_load=%b expected 0", k, PC_load);
      end
      exp_stalls++;
    end
    idle(1);
    n_checks++;
    if (PC_load !== 1'b1) begin
      n_fail++; $display("FAIL rm_mul_release: PC_load=%b expected 1", PC_load);
    end
    idle(4);
    n_checks++;
    if (q.size() != 0 || stall_count !== CW'(exp_stalls)) begin
      n_fail++; $display("FAIL rm_drain: outstanding=%0d stall_count=%0d expected 0/%0d", q.size(), stall_count, exp_stalls);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_branch();
    test_decode();
    test_jump_stall();
    test_zero_dest_unknown();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_pipeline_control.md
Name: mips_pipeline_control

Overview:
- Next-generation control unit for the 5-stage MIPS pipeline (IF/ID/EX/MA/WB).
- Decodes opcode/funct in ID and carries the control bundle through registered ID/EX, EX/MA and MA/WB stages.
- Detects load-use hazards, stalls for a multi-cycle multiplier (parameterised latency), resolves BEQ/BNE in EX, and generates stall/flush/jump controls plus a saturating stall counter.

Parameters:
REG_ADDR_W, 5, register address width
MUL_CYCLES, 3, EX occupancy of MUL in cycles (>=1; 1 = no stall)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  ID holds a real instruction (0 = bubble)
opcode  in  6  ID opcode
funct  in  6  ID funct
rs_id, rt_id, rd_id  in  REG_ADDR_W each  ID register fields
alu_zero_ex  in  1  ALU zero flag of the EX instruction
PC_load  out  1  PC write enable
EN_to_pipelineReg1  out  1  IF/ID register enable
flush_ifid  out  1  clear IF/ID to bubble at next edge
select_jumpD  out  1  select jump target for PC
branch_taken  out  1  select branch target for PC
ex_RegDst, ex_ALUsrc, ex_Slt_select, ex_shift_or_not, ex_shift_direction  out  1 each  EX controls
ex_ALUOp  out  3  EX ALU operation
ma_MemRead, ma_MemWrite  out  1 each  MA controls
wb_RegWrite, wb_MemtoReg  out  1 each  WB controls
wb_dest  out  REG_ADDR_W  WB destination register
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Decode (combinational, ID):
  - ALU codes: ADD 000, SUB 001, AND 100, OR 101, XOR 110, MUL 010, NOP 111.
  - R-type (op 000000):
    - RegWrite=1, RegDst=1.
    - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 101100 MUL.
    - funct 101010: Slt_select=1, ALUOp=NOP.
    - funct 000000: shift_or_not=1, direction=0 (left); funct 000010: shift_or_not=1, direction=1 (right).
    - Any other funct: RegWrite=0, ALUOp=NOP.
  - I-type, all with ALUsrc=1 and RegDst=0:
    - ADDI 001000 → ADD; ANDI 001100 → AND; ORI 001101 → OR; SLTI 001010 → OR with Slt_select=1.
    - LW 100011 → ADD, MemRead=1, MemtoReg=1, RegWrite=1.
    - SW 101011 → ADD, MemWrite=1.
  - BEQ 000100 / BNE 000101 → SUB, branch=1, is_bne=(op==BNE).
  - J 000010 → jump.
  - Unknown opcode, or instr_valid=0 → bubble: all controls 0, ALUOp=111.
  - dest = RegDst ? rd_id : rt_id; if dest==0, RegWrite is forced to 0.
  - uses_rt = R-type | SW | BEQ | BNE.
- Pipeline: ID/EX, EX/MA and MA/WB registers each advance every cycle unless frozen.
- Reset (asynchronous): all stage registers become bubbles (ALUOp=111, all other fields 0); mul_cnt=0; stall_count=0. Combinational outputs follow: PC_load=1, EN_to_pipelineReg1=1, flush_ifid=0, select_jumpD=0, branch_taken=0.
- Priority: branch_taken > mul stall > load-use stall > jump.
- branch_taken = ex_branch & (ex_is_bne ? ~alu_zero_ex : alu_zero_ex).
  - When asserted: flush_ifid=1, ID/EX loads a bubble, select_jumpD=0, no stall.
  - Branch penalty: 2 cycles.
- Mul stall: while EX holds MUL and mul_cnt < MUL_CYCLES-1:
  - PC_load=0, EN=0, ID/EX holds, EX/MA loads a bubble, mul_cnt increments.
  - On the final cycle: mul_cnt returns to 0 and the pipeline advances.
- Load-use stall: ex_MemRead & ex_dest≠0 & (ex_dest==rs_id | (uses_rt & ex_dest==rt_id)).
  - Effect: PC_load=0, EN=0, ID/EX loads a bubble. Duration: exactly 1 cycle.
- Jump in ID, no stall or branch active: select_jumpD=1, flush_ifid=1 (1-cycle penalty). While stalled, jump outputs are 0 until the stall releases.
- stall_count increments on every cycle with PC_load=0 and saturates at all-ones.
- MA and WB controls are pure delays of the EX bundle; wb_dest=0 whenever wb_RegWrite=0.

Test Plan:
- LW $2,0($1) then ADD $3,$2,$4 → exactly 1 cycle PC_load=0; ADD reaches EX one cycle late; stall_count=1.
- MUL $5,$6,$7 with MUL_CYCLES=3 → PC_load=0 for 2 cycles; 2 bubbles enter MA; following ADD reaches WB 2 cycles late.
- BEQ with alu_zero_ex=1 → branch_taken=1, flush_ifid=1, ID/EX bubble; BNE with alu_zero_ex=1 → branch_taken=0, no flush.
- J in ID while LW→dependent stall is active → select_jumpD=0 during the stall, =1 on the following cycle.
- ADDI $0,$1,5 → wb_RegWrite=0 and wb_dest=0 at WB; unknown opcode 111111 → full bubble.
- Assert rst during the 2nd MUL stall cycle → outputs immediately return to reset values; mul_cnt=0; the next instruction flows with no residual stall.
